// File: rtl/imem_responder.sv
// imem_responder: single-port word memory answering the fetch-path
// mem_in_type/mem_out_type protocol. It serves reads and byte-masked writes
// after a programmable number of wait states and acknowledges fences. A
// pending access is dropped when the requester changes its address, drops
// valid or raises a fence.

package imem_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

module imem_responder
    import imem_pkg::*;
#(
    parameter int imem_depth   = 10,
    parameter int wait_cycles  = 2,
    parameter int fence_cycles = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out
);

    localparam int WORDS = 1 << imem_depth;

    // The counter holds the number of wait cycles still to pass after the
    // current one. A zero setting therefore completes on the accepting edge.
    localparam logic [3:0] WAIT_LOAD  = 4'((wait_cycles  > 0) ? wait_cycles  - 1 : 0);
    localparam logic [3:0] FENCE_LOAD = 4'((fence_cycles > 0) ? fence_cycles - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FENCE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [WORDS];

    logic                  take_req;
    logic                  take_fence;
    logic                  do_acc;
    logic                  do_ack;
    logic [imem_depth-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_wstrb;

    // The instruction flag and the byte offset do not influence behaviour.
    logic unused_in;
    assign unused_in = ^{imem_in.mem_instr, imem_in.mem_addr[1:0]};

    // Next-state decode. Completion lands in IDLE, so the mem_ready cycle
    // is evaluated as IDLE and a new request can be taken right away.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ready_d    = 1'b0;
        rdata_d    = rdata_q;
        take_req   = 1'b0;
        take_fence = 1'b0;
        do_acc     = 1'b0;
        do_ack     = 1'b0;
        acc_idx    = addr_q[imem_depth-1:0];
        acc_wdata  = wdata_q;
        acc_wstrb  = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (imem_in.mem_valid) begin
                    if (imem_in.mem_fence) take_fence = 1'b1;
                    else                   take_req   = 1'b1;
                end
            end
            WAIT: begin
                // Priority: fence, dropped valid, redirect, then completion.
                if (imem_in.mem_valid && imem_in.mem_fence) begin
                    take_fence = 1'b1;
                end else if (!imem_in.mem_valid) begin
                    state_d = IDLE;
                end else if (imem_in.mem_addr[31:2] != addr_q) begin
                    take_req = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_acc  = 1'b1;
                    state_d = IDLE;
                end
            end
            FENCE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_ack  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_fence) begin
            if (fence_cycles == 0) begin
                do_ack  = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d   = FENCE_LOAD;
                state_d = FENCE;
            end
        end

        if (take_req) begin
            addr_d  = imem_in.mem_addr[31:2];
            wdata_d = imem_in.mem_wdata;
            wstrb_d = imem_in.mem_wstrb;
            if (wait_cycles == 0) begin
                // No wait states: complete from the live request.
                do_acc    = 1'b1;
                acc_idx   = imem_in.mem_addr[imem_depth+1:2];
                acc_wdata = imem_in.mem_wdata;
                acc_wstrb = imem_in.mem_wstrb;
                state_d   = IDLE;
            end else begin
                cnt_d   = WAIT_LOAD;
                state_d = WAIT;
            end
        end

        if (do_acc) begin
            ready_d = 1'b1;
            rdata_d = (acc_wstrb == 4'd0) ? mem_q[acc_idx] : 32'd0;
        end

        if (do_ack) begin
            ready_d = 1'b1;
            rdata_d = 32'd0;
        end
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Array update: byte lanes are written only on a completing edge that
    // is not also a reset edge, so aborted writes never land.
    always_ff @(posedge clk) begin
        if (rst && do_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    // Only ready and rdata are driven; every other response bit stays low.
    always_comb begin
        imem_out           = '0;
        imem_out.mem_ready = ready_q;
        imem_out.mem_rdata = rdata_q;
    end

endmodule
